// File: rtl/md_rx_arbiter_pkg.sv
// Shared types and width helpers for the MD RX arbiter.
package md_rx_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam int DEF_STALL_LIMIT = 64;

  // Byte-offset field width for a data bus of dw bits (never narrower than 1).
  function automatic int calc_offw(input int dw);
    int w;
    w = $clog2(dw / 8);
    return (w < 1) ? 1 : w;
  endfunction

  // Size field width: must encode 0..bytes-per-beat inclusive.
  function automatic int calc_szw(input int dw);
    return $clog2(dw / 8) + 1;
  endfunction

endpackage

// File: rtl/md_rx_arbiter_rr_picker.sv
// Round-robin picker: first set request strictly after last_i, wrapping.
module rr_picker #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] winner_o,
  output logic          any_o
);

  // Scan last+1 .. last+N (mod N); the first hit wins.
  always_comb begin
    int idx;
    winner_o = '0;
    any_o    = 1'b0;
    idx      = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last_i) + i) % N;
      if (!any_o && req_i[IW'(idx)]) begin
        any_o    = 1'b1;
        winner_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/md_rx_arbiter.sv
// Arbitrates NUM_REQ MD requesters onto one MD RX master port.
// One transfer in flight: accept in IDLE, present held payload in SEND.
module md_rx_arbiter
  import md_rx_arbiter_pkg::*;
#(
  parameter  int ALGN_DATA_WIDTH = 32,
  parameter  int NUM_REQ         = 4,
  parameter  int STALL_LIMIT     = DEF_STALL_LIMIT,
  localparam int OFFW            = calc_offw(ALGN_DATA_WIDTH),
  localparam int SZW             = calc_szw(ALGN_DATA_WIDTH),
  localparam int IDW             = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*ALGN_DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*OFFW-1:0]            req_offset,
  input  logic [NUM_REQ*SZW-1:0]             req_size,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 req_done,
  output logic [NUM_REQ-1:0]                 req_err,
  output logic                               md_rx_valid,
  output logic [ALGN_DATA_WIDTH-1:0]         md_rx_data,
  output logic [OFFW-1:0]                    md_rx_offset,
  output logic [SZW-1:0]                     md_rx_size,
  input  logic                               md_rx_ready,
  input  logic                               md_rx_err,
  output logic [IDW-1:0]                     grant_id,
  output logic                               stall,
  input  logic                               stall_clr
);

  localparam int              CNTW    = $clog2(STALL_LIMIT + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(STALL_LIMIT);
  localparam logic [CNTW-1:0] CNT_PRE = CNTW'(STALL_LIMIT - 1);

  state_e                     state_q;
  logic [IDW-1:0]             grant_id_q, last_grant_q;
  logic                       md_rx_valid_q;
  logic [ALGN_DATA_WIDTH-1:0] data_q;
  logic [OFFW-1:0]            offset_q;
  logic [SZW-1:0]             size_q;
  logic [NUM_REQ-1:0]         req_done_q, req_err_q;
  logic [CNTW-1:0]            stall_cnt_q, stall_cnt_d;
  logic                       stall_q, stall_d, stall_set;

  logic [IDW-1:0]             winner;
  logic                       any;
  logic                       accept, hs;
  logic [ALGN_DATA_WIDTH-1:0] win_data;
  logic [OFFW-1:0]            win_offset;
  logic [SZW-1:0]             win_size;

  rr_picker #(.N(NUM_REQ)) u_pick (
    .req_i    (req_valid),
    .last_i   (last_grant_q),
    .winner_o (winner),
    .any_o    (any)
  );

  assign accept = (state_q == ST_IDLE) && any;
  assign hs     = (state_q == ST_SEND) && md_rx_ready;

  // Select the winner's slice of the flattened request buses.
  always_comb begin
    win_data   = '0;
    win_offset = '0;
    win_size   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDW'(i)) begin
        win_data   = req_data[i*ALGN_DATA_WIDTH +: ALGN_DATA_WIDTH];
        win_offset = req_offset[i*OFFW +: OFFW];
        win_size   = req_size[i*SZW +: SZW];
      end
    end
  end

  // Accept strobe is combinational so the requester sees it in the pick cycle.
  always_comb begin
    req_ready = '0;
    if (!reset && accept) req_ready[winner] = 1'b1;
  end

  // Stall counter saturates; the flag is set only on the transition into the
  // limit so a later stall_clr can clear it even while still saturated.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    stall_set   = 1'b0;
    if (accept) begin
      stall_cnt_d = '0;
    end else if (state_q == ST_SEND && !md_rx_ready) begin
      if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
      stall_set = (stall_cnt_q == CNT_PRE);
    end
    stall_d = stall_q;
    if (stall_set)      stall_d = 1'b1;
    else if (stall_clr) stall_d = 1'b0;
  end

  // Stall state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_d;
    end
  end

  // Main FSM: capture on accept, hold until handshake, pulse done/err.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      md_rx_valid_q <= 1'b0;
      data_q        <= '0;
      offset_q      <= '0;
      size_q        <= '0;
      grant_id_q    <= '0;
      last_grant_q  <= IDW'(NUM_REQ - 1);
      req_done_q    <= '0;
      req_err_q     <= '0;
    end else begin
      req_done_q <= '0;
      req_err_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q       <= ST_SEND;
            md_rx_valid_q <= 1'b1;
            data_q        <= win_data;
            offset_q      <= win_offset;
            size_q        <= win_size;
            grant_id_q    <= winner;
            last_grant_q  <= winner;
          end
        end
        ST_SEND: begin
          if (hs) begin
            state_q                <= ST_IDLE;
            md_rx_valid_q          <= 1'b0;
            req_done_q[grant_id_q] <= 1'b1;
            req_err_q[grant_id_q]  <= md_rx_err;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign md_rx_valid  = md_rx_valid_q;
  assign md_rx_data   = data_q;
  assign md_rx_offset = offset_q;
  assign md_rx_size   = size_q;
  assign req_done     = req_done_q;
  assign req_err      = req_err_q;
  assign grant_id     = grant_id_q;
  assign stall        = stall_q;

endmodule

// File: tb/tb_md_rx_arbiter.sv
// Directed bench for md_rx_arbiter (4 requesters, 32-bit data).
module tb_md_rx_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int OW = 2;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N*OW-1:0] req_offset;
  logic [N*SW-1:0] req_size;
  logic [N-1:0]   req_ready, req_done, req_err;
  logic           md_rx_valid;
  logic [W-1:0]   md_rx_data;
  logic [OW-1:0]  md_rx_offset;
  logic [SW-1:0]  md_rx_size;
  logic           md_rx_ready, md_rx_err;
  logic [1:0]     grant_id;
  logic           stall, stall_clr;

  int checks   = 0;
  int failures = 0;

  md_rx_arbiter #(.ALGN_DATA_WIDTH(W), .NUM_REQ(N), .STALL_LIMIT(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data),
    .req_offset(req_offset), .req_size(req_size),
    .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
    .md_rx_valid(md_rx_valid), .md_rx_data(md_rx_data),
    .md_rx_offset(md_rx_offset), .md_rx_size(md_rx_size),
    .md_rx_ready(md_rx_ready), .md_rx_err(md_rx_err),
    .grant_id(grant_id), .stall(stall), .stall_clr(stall_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] src_d(input int i);
    return 32'hC0DE_0000 + 32'(i * 32'h0101);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [N-1:0] e;
    int w;
    reset = 1'b1; req_valid = '1; md_rx_ready = 1'b0; md_rx_err = 1'b0; stall_clr = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_data[i*W +: W]    = src_d(i);
      req_offset[i*OW +: OW] = OW'(i);
      req_size[i*SW +: SW]   = SW'(i + 1);
    end

    // Reset state
    tick(); tick(); tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", md_rx_valid, 0);
    chk("rst_data", md_rx_data, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", req_done, 0);
    req_valid = '0;
    reset = 1'b0;

    // Idle with no requests
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_valid", md_rx_valid, 0);
      chk("idle_ready", req_ready, 0);
    end

    // Round robin with all requesting, sink always ready
    req_valid = 4'b1111; md_rx_ready = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      w = k % 4;
      e = 4'b0001 << w;
      chk("rr_ready", req_ready, e);
      if (k > 0) chk("rr_done", req_done, 4'b0001 << ((k - 1) % 4));
      tick();
      chk("rr_valid", md_rx_valid, 1);
      chk("rr_grant", grant_id, w);
      chk("rr_data", md_rx_data, src_d(w));
      chk("rr_offset", md_rx_offset, w);
      chk("rr_size", md_rx_size, w + 1);
      chk("rr_ready_send", req_ready, 0);
      tick();
    end
    req_valid = '0; #1;
    chk("rr_last_done", req_done, 4'b0001);
    chk("rr_err", req_err, 0);
    chk("rr_idle_ready", req_ready, 0);

    // Requester 2 alone, sink stalled for 70 cycles
    md_rx_ready = 1'b0; req_valid = 4'b0100; #1;
    chk("st_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    for (int c = 1; c <= 70; c++) begin
      if (c == 10) req_valid = 4'b1000;
      if (c == 20) req_valid = 4'b0000;
      #1;
      chk("st_valid", md_rx_valid, 1);
      chk("st_data", md_rx_data, src_d(2));
      if (c == 10) chk("st_no_ready", req_ready, 0);
      if (c == 64) chk("st_stall_pre", stall, 0);
      if (c == 65) chk("st_stall_set", stall, 1);
      if (c == 68) stall_clr = 1'b1;
      if (c == 69) begin chk("st_stall_clr", stall, 0); stall_clr = 1'b0; end
      tick();
    end
    md_rx_ready = 1'b1; #1;
    chk("st_grant", grant_id, 2);
    chk("st_done_early", req_done, 0);
    tick();
    chk("st_done", req_done, 4'b0100);
    chk("st_err", req_err, 0);
    chk("st_valid_off", md_rx_valid, 0);
    md_rx_ready = 1'b0;

    // Error response on requester 1
    req_valid = 4'b0010; md_rx_ready = 1'b1; md_rx_err = 1'b1; #1;
    chk("er_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    chk("er_grant", grant_id, 1);
    tick();
    chk("er_done", req_done, 4'b0010);
    chk("er_err", req_err, 4'b0010);
    tick();
    chk("er_done_clr", req_done, 0);
    chk("er_err_clr", req_err, 0);
    chk("er_idle_valid", md_rx_valid, 0);
    tick();
    chk("idle_hs_done", req_done, 0);
    chk("idle_hs_err", req_err, 0);
    md_rx_ready = 1'b0; md_rx_err = 1'b0;

    // stall_clr coinciding with stall set: set wins
    req_valid = 4'b0001; #1;
    chk("sc_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    for (int c = 1; c <= 64; c++) begin
      if (c == 64) begin chk("sc_stall_pre", stall, 0); stall_clr = 1'b1; end
      tick();
    end
    stall_clr = 1'b0;
    chk("sc_stall_wins", stall, 1);
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    chk("sc_stall_clr", stall, 0);
    md_rx_ready = 1'b1;
    tick();
    chk("sc_done", req_done, 4'b0001);
    md_rx_ready = 1'b0;

    // Reset during SEND cycle 3
    req_valid = 4'b1000; #1;
    chk("rs_ready", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("rs_valid_pre", md_rx_valid, 1);
    reset = 1'b1;
    tick();
    chk("rs_valid", md_rx_valid, 0);
    chk("rs_done", req_done, 0);
    chk("rs_grant", grant_id, 0);
    chk("rs_data", md_rx_data, 0);
    req_valid = 4'b1111; #1;
    chk("rs_ready_in_rst", req_ready, 0);
    reset = 1'b0; #1;
    chk("rs_first", req_ready, 4'b0001);
    tick();
    chk("rs_first_grant", grant_id, 0);
    chk("rs_first_data", md_rx_data, src_d(0));
    chk("rs_no_done", req_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
